// File: rtl/sd_clkgen.sv
// SD card clock generator: programmable divider, edge strobes, stop/hold and init burst.
// Optional hold support is compiled in with SD_CLKGEN_HOLD_EN; without it, hold is ignored.
module sd_clkgen #(
    parameter int DIV_W       = 8,
    parameter int DIV_RESET   = 124,
    parameter int INIT_CYCLES = 80
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             div_req,
    output logic             div_ack,
    input  logic             clk_en,
    input  logic             hold,
    input  logic             init_req,
    output logic             init_busy,
    output logic             sd_clk,
    output logic             sd_clk_rising,
    output logic             sd_clk_falling,
    output logic             clk_running
);

    localparam int ICNT_W = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN_LO  = 2'd1,
        ST_RUN_HI  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DIV_W-1:0]   r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0]   r_div_cur;
    logic               r_div_req_q;
    logic               r_div_ack;
    logic               r_sd_clk, w_sd_clk_nxt;
    logic               r_rise, w_rise_nxt;
    logic               r_fall, w_fall_nxt;
    logic               r_init_busy;
    logic [ICNT_W-1:0]  r_icnt;

    logic               w_hold;
    logic               w_run;
    logic               w_load;
    logic [DIV_W-1:0]   w_div_eff;

`ifdef SD_CLKGEN_HOLD_EN
    assign w_hold = hold;
`else
    // Hold is ignored in this build; the port stays so both builds share one pinout.
    assign w_hold = hold & 1'b0;
`endif

    assign w_run = (clk_en | r_init_busy) & ~w_hold;

    // A new divider only lands at the start of a low phase (or while stopped), so the
    // low phase that follows is timed entirely with the new value and never glitches.
    assign w_load    = (div_req != r_div_req_q) &&
                       ((r_state == ST_STOPPED) || ((r_state == ST_RUN_LO) && (r_cnt == '0)));
    assign w_div_eff = w_load ? div : r_div_cur;

    // NOTE: every variable is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sd_clk_nxt = r_sd_clk;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        case (r_state)
            ST_STOPPED: begin
                w_cnt_nxt    = '0;
                w_sd_clk_nxt = 1'b0;
                if (w_run) w_state_nxt = ST_RUN_LO;
            end
            ST_RUN_LO: begin
                if (r_cnt == w_div_eff) begin
                    w_cnt_nxt = '0;
                    if (w_run) begin
                        w_sd_clk_nxt = 1'b1;
                        w_rise_nxt   = 1'b1;
                        w_state_nxt  = ST_RUN_HI;
                    end else begin
                        w_state_nxt  = ST_STOPPED;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN_HI: begin
                // The high phase always completes; stopping is only decided at the end of low.
                if (r_cnt == r_div_cur) begin
                    w_cnt_nxt    = '0;
                    w_sd_clk_nxt = 1'b0;
                    w_fall_nxt   = 1'b1;
                    w_state_nxt  = ST_RUN_LO;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt    = '0;
                w_sd_clk_nxt = 1'b0;
                w_state_nxt  = ST_STOPPED;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_STOPPED;
            r_cnt       <= '0;
            r_div_cur   <= DIV_W'(DIV_RESET);
            r_div_req_q <= 1'b0;
            r_div_ack   <= 1'b0;
            r_sd_clk    <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_init_busy <= 1'b0;
            r_icnt      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sd_clk <= w_sd_clk_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;

            if (w_load) begin
                r_div_cur   <= div;
                r_div_req_q <= div_req;
                r_div_ack   <= ~r_div_ack;
            end

            // Burst progress advances on the rising strobe, so a hold simply pauses it.
            if (r_init_busy) begin
                if (r_rise) begin
                    r_icnt <= r_icnt - 1'b1;
                    if (r_icnt == ICNT_W'(1)) r_init_busy <= 1'b0;
                end
            end else if (init_req) begin
                r_init_busy <= 1'b1;
                r_icnt      <= ICNT_W'(INIT_CYCLES);
            end
        end
    end

    assign div_ack        = r_div_ack;
    assign init_busy      = r_init_busy;
    assign sd_clk         = r_sd_clk;
    assign sd_clk_rising  = r_rise;
    assign sd_clk_falling = r_fall;
    assign clk_running    = (r_state != ST_STOPPED);

endmodule
